// File: rtl/mbscore_fetch_unit.sv
// Instruction-fetch responder for the multicycle core controller.
// Owns the PC, performs one memory read per accepted fetch over a
// req/ack handshake, and applies controller-commanded PC updates.
// Halt, PC misalignment and memory timeout are handled locally.
module mbscore_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    output logic                  fetch_ready,
    input  logic                  pc_upd,
    input  logic [1:0]            pc_sel,
    input  logic [15:0]           imm,
    input  logic [25:0]           target,
    input  logic [ADDR_WIDTH-1:0] jr_addr,
    input  logic                  hlt,
    output logic [DATA_WIDTH-1:0] inst,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  fetch_err,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_DONE = 3'd2,
        S_HALT = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Value the wait counter holds on the last permitted cycle without ack.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t                state;
    logic [7:0]            wait_cnt;
    logic                  stale;     // PC moved while the current read was in flight
    logic                  hlt_pend;  // halt requested while a read was in flight
    logic                  upd_ok;    // pc_upd takes effect this cycle
    logic [ADDR_WIDTH-1:0] pc_nxt;

    // Next PC for a given select; all arithmetic wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] calc_pc(
        input logic [ADDR_WIDTH-1:0] cur,
        input logic [1:0]            sel,
        input logic [15:0]           off,
        input logic [25:0]           tgt,
        input logic [ADDR_WIDTH-1:0] jr
    );
        logic        [ADDR_WIDTH-1:0] seq;
        logic signed [ADDR_WIDTH-1:0] br;
        seq = cur + ADDR_WIDTH'(4);
        br  = {{(ADDR_WIDTH-18){off[15]}}, off, 2'b00};
        case (sel)
            2'b00:   calc_pc = seq;
            2'b01:   calc_pc = seq + br;
            2'b10:   calc_pc = {seq[ADDR_WIDTH-1:28], tgt, 2'b00};
            default: calc_pc = jr;
        endcase
    endfunction

    // A PC update is honoured only in live states and loses to any halt.
    always_comb begin
        upd_ok = pc_upd && !hlt && !hlt_pend &&
                 ((state == S_IDLE) || (state == S_REQ) || (state == S_DONE));
        pc_nxt = upd_ok ? calc_pc(pc, pc_sel, imm, target, jr_addr) : pc;
    end

    assign fetch_ready = (state == S_IDLE);

    // Fetch controller: state, PC, handshake and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            mem_addr   <= RESET_PC;
            mem_req    <= 1'b0;
            inst       <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            fetch_err  <= 1'b0;
            wait_cnt   <= '0;
            stale      <= 1'b0;
            hlt_pend   <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            pc         <= pc_nxt;
            case (state)
                S_IDLE: begin
                    if (hlt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (fetch_req) begin
                        // The fetch uses the PC after any coincident update.
                        if (pc_nxt[1:0] != 2'b00) begin
                            state     <= S_ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            state    <= S_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc_nxt;
                            wait_cnt <= '0;
                            stale    <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req) begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            if (hlt_pend || hlt) begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end else if (stale || upd_ok) begin
                                // Data belongs to the old PC: drop it, idle one
                                // cycle with mem_req low, then re-issue.
                                stale <= 1'b0;
                            end else begin
                                state      <= S_DONE;
                                inst       <= mem_rdata;
                                inst_valid <= 1'b1;
                            end
                        end else begin
                            if (hlt)    hlt_pend <= 1'b1;
                            if (upd_ok) stale    <= 1'b1;
                            if (wait_cnt == TMO_LAST) begin
                                mem_req   <= 1'b0;
                                state     <= S_ERR;
                                fetch_err <= 1'b1;
                            end else begin
                                wait_cnt <= wait_cnt + 8'd1;
                            end
                        end
                    end else begin
                        // Gap cycle after a discarded read.
                        if (hlt || hlt_pend) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else if (pc_nxt[1:0] != 2'b00) begin
                            state     <= S_ERR;
                            fetch_err <= 1'b1;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc_nxt;
                            wait_cnt <= '0;
                        end
                    end
                end
                S_DONE: begin
                    if (hlt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: state <= S_HALT;
                S_ERR:  state <= S_ERR;
                default: begin
                    state     <= S_ERR;
                    fetch_err <= 1'b1;
                end
            endcase
        end
    end

endmodule
